// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter: FSM state encoding and
//   requester identifiers used by the top and by the priority sub-module.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arbState_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arb_priority.sv
// ----------------------------------------------------------------------------
// mem_arb_priority
//   Combinational winner select between the fetch (IF) and data (D)
//   requesters, plus the saturating starvation counter that forces IF through
//   after STARVE_MAX consecutive D wins while IF was waiting.
// Ports
//   clk, rst      clock / asynchronous active-high reset
//   arbEn_i       high while the arbiter is able to take a decision (IDLE)
//   ifReq_i       fetch request
//   dReq_i        data request
//   winner_o      REQ_IF or REQ_D (meaningful only when anyReq_o is high)
//   anyReq_o      at least one request is pending
// ----------------------------------------------------------------------------
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic arbEn_i,
    input  logic ifReq_i,
    input  logic dReq_i,
    output logic winner_o,
    output logic anyReq_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starveCnt_q;
    logic [CW-1:0] starveCnt_d;
    logic          starved;

    assign starved  = (starveCnt_q == CW'(STARVE_MAX));
    assign anyReq_o = ifReq_i | dReq_i;

    // D normally wins; IF gets through when alone or when it has been starved.
    always_comb begin
        winner_o = REQ_D;
        if (ifReq_i && (!dReq_i || starved)) begin
            winner_o = REQ_IF;
        end
    end

    // The counter only moves on an actual arbitration decision. A D win with
    // no IF waiting leaves it alone, so IF is not penalised for idling.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (arbEn_i && anyReq_o) begin
            if (winner_o == REQ_IF) begin
                starveCnt_d = '0;
            end else if (ifReq_i && !starved) begin
                starveCnt_d = starveCnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port SRAM between instruction fetch (read-only) and data
//   access (LW/SW). One transaction in flight; sequence IDLE -> ISSUE ->
//   (reads) WAIT x MEM_LAT -> RESP -> IDLE. All outputs are registered.
// Ports
//   clk, rst                      clock / asynchronous active-high reset
//   if_req, if_addr               fetch request, held until if_gnt
//   if_gnt, if_rvalid, if_rdata   fetch grant pulse, response pulse, data
//   d_req, d_we, d_addr, d_wdata  data request, held until d_gnt
//   d_gnt, d_rvalid, d_rdata      data grant pulse, read response pulse, data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata          memory macro interface
//   busy                          high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LW = $clog2(MEM_LAT + 1);

    arbState_t         state_q,    state_d;
    logic [LW-1:0]     latCnt_q,   latCnt_d;
    logic              winner_q,   winner_d;
    logic              memEn_q,    memEn_d;
    logic              memWe_q,    memWe_d;
    logic [ADDR_W-1:0] memAddr_q,  memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              ifGnt_q,    ifGnt_d;
    logic              dGnt_q,     dGnt_d;
    logic              ifRvalid_q, ifRvalid_d;
    logic              dRvalid_q,  dRvalid_d;
    logic [DATA_W-1:0] ifRdata_q,  ifRdata_d;
    logic [DATA_W-1:0] dRdata_q,   dRdata_d;
    logic              busy_q,     busy_d;

    logic arbWinner;
    logic anyReq;
    logic arbEn;
    logic issueNow;
    logic capture;

    assign arbEn    = (state_q == ST_IDLE);
    assign issueNow = arbEn && anyReq;
    // mem_rdata is valid on the final WAIT cycle, when the countdown reaches 1.
    assign capture  = (state_q == ST_WAIT) && (latCnt_q == LW'(1));

    mem_arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_priority (
        .clk      (clk),
        .rst      (rst),
        .arbEn_i  (arbEn),
        .ifReq_i  (if_req),
        .dReq_i   (d_req),
        .winner_o (arbWinner),
        .anyReq_o (anyReq)
    );

    // State register plus the registers that belong to the FSM itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            latCnt_q <= '0;
            winner_q <= REQ_IF;
        end else begin
            state_q  <= state_d;
            latCnt_q <= latCnt_d;
            winner_q <= winner_d;
        end
    end

    // Next-state logic. Writes finish straight after ISSUE; reads count down
    // the memory latency before the response cycle.
    always_comb begin
        state_d  = state_q;
        latCnt_d = latCnt_q;
        winner_d = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    state_d  = ST_ISSUE;
                    winner_d = arbWinner;
                end
            end
            ST_ISSUE: begin
                if (memWe_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_WAIT;
                    latCnt_d = LW'(MEM_LAT);
                end
            end
            ST_WAIT: begin
                latCnt_d = latCnt_q - LW'(1);
                if (latCnt_q == LW'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic. Values are computed one cycle early so that the output
    // registers line up with the state they belong to (ISSUE / RESP).
    always_comb begin
        memEn_d    = issueNow;
        memWe_d    = issueNow && (arbWinner == REQ_D) && d_we;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        if (issueNow) begin
            memAddr_d = (arbWinner == REQ_D) ? d_addr : if_addr;
            if (arbWinner == REQ_D) begin
                memWdata_d = d_wdata;
            end
        end
        ifGnt_d    = issueNow && (arbWinner == REQ_IF);
        dGnt_d     = issueNow && (arbWinner == REQ_D);
        ifRvalid_d = capture && (winner_q == REQ_IF);
        dRvalid_d  = capture && (winner_q == REQ_D);
        ifRdata_d  = ifRvalid_d ? mem_rdata : ifRdata_q;
        dRdata_d   = dRvalid_d ? mem_rdata : dRdata_q;
        busy_d     = (state_d != ST_IDLE);
    end

    // Output registers; reset discards any in-flight access and its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            ifGnt_q    <= 1'b0;
            dGnt_q     <= 1'b0;
            ifRvalid_q <= 1'b0;
            dRvalid_q  <= 1'b0;
            ifRdata_q  <= '0;
            dRdata_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            memEn_q    <= memEn_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            ifGnt_q    <= ifGnt_d;
            dGnt_q     <= dGnt_d;
            ifRvalid_q <= ifRvalid_d;
            dRvalid_q  <= dRvalid_d;
            ifRdata_q  <= ifRdata_d;
            dRdata_q   <= dRdata_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_en    = memEn_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign if_gnt    = ifGnt_q;
    assign d_gnt     = dGnt_q;
    assign if_rvalid = ifRvalid_q;
    assign d_rvalid  = dRvalid_q;
    assign if_rdata  = ifRdata_q;
    assign d_rdata   = dRdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Scoreboard bench: every request pushes its expected grant / response
//   (requester, cycle, address, data) into queues; a negedge monitor pops and
//   compares them as the arbiter produces grants and responses. The memory
//   model returns ~addr exactly MEM_LAT cycles after mem_en, garbage otherwise.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;

    typedef struct {
        bit          isD;
        bit          we;
        int          gntCyc;
        int          rvCyc;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } expTxn_t;

    expTxn_t gntQ[$];
    expTxn_t rvQ[$];
    expTxn_t gE, rE;

    int cyc       = 0;
    int numChecks = 0;
    int numFails  = 0;

    logic [MEM_LAT-1:0]      memValid    = '0;
    logic [MEM_LAT-1:0][7:0] memAddrPipe = '0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears only on the cycle MEM_LAT after mem_en.
    always @(posedge clk) begin
        memValid[0]    <= mem_en && !mem_we;
        memAddrPipe[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            memValid[i]    <= memValid[i-1];
            memAddrPipe[i] <= memAddrPipe[i-1];
        end
    end

    assign mem_rdata = memValid[MEM_LAT-1] ? ~{24'h0, memAddrPipe[MEM_LAT-1]} : 32'hDEADBEEF;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pushExpect(input bit isD, input bit we, input logic [7:0] addr,
                              input logic [31:0] wdata, input int gntCyc, input int rvCyc);
        expTxn_t e;
        e.isD    = isD;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wdata;
        e.gntCyc = gntCyc;
        e.rvCyc  = rvCyc;
        gntQ.push_back(e);
        if (rvCyc >= 0) rvQ.push_back(e);
    endtask

    // Raises a request in the current cycle and records when its grant and
    // (for reads) its response are due, relative to this cycle.
    task automatic applyStimulus(input bit isD, input bit we, input logic [7:0] addr,
                                 input logic [31:0] wdata, input int gntOff, input int rvOff);
        if (isD) begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        pushExpect(isD, we, addr, wdata, cyc + gntOff, (rvOff < 0) ? -1 : cyc + rvOff);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for the next grant of either requester; returns just after the
    // following rising edge so the requester may update or drop its request.
    task automatic waitAnyGnt(input string tag, output bit gotD);
        bit seen = 1'b0;
        gotD = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                seen = 1'b1;
                gotD = d_gnt;
            end
        end
        if (!seen) checkOutput({tag, " gnt timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic grantAndDrop(input string tag);
        bit gotD;
        waitAnyGnt(tag, gotD);
        if (gotD) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " 1-bit outputs"},
                    {25'b0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, 32'd0);
        checkOutput({tag, " if_rdata"},  if_rdata, 32'd0);
        checkOutput({tag, " d_rdata"},   d_rdata, 32'd0);
        checkOutput({tag, " mem_addr"},  {24'b0, mem_addr}, 32'd0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every grant and every response.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) checkOutput("mem_en has gnt", {31'b0, if_gnt | d_gnt}, 32'd1);
            else        checkOutput("mem_we idle", {31'b0, mem_we}, 32'd0);
            if (if_gnt || d_gnt) begin
                if (gntQ.size() == 0) begin
                    checkOutput("unexpected gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
                end else begin
                    gE = gntQ.pop_front();
                    checkOutput("gnt requester", {30'b0, if_gnt, d_gnt}, gE.isD ? 32'd1 : 32'd2);
                    checkOutput("gnt cycle", cyc, gE.gntCyc);
                    checkOutput("mem_addr", {24'b0, mem_addr}, {24'b0, gE.addr});
                    checkOutput("mem_we", {31'b0, mem_we}, {31'b0, gE.we});
                    if (gE.we) checkOutput("mem_wdata", mem_wdata, gE.wdata);
                end
            end
            if (if_rvalid || d_rvalid) begin
                if (rvQ.size() == 0) begin
                    checkOutput("unexpected rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
                end else begin
                    rE = rvQ.pop_front();
                    checkOutput("rvalid requester", {30'b0, if_rvalid, d_rvalid}, rE.isD ? 32'd1 : 32'd2);
                    checkOutput("rvalid cycle", cyc, rE.rvCyc);
                    checkOutput("rdata", rE.isD ? d_rdata : if_rdata, ~{24'h0, rE.addr});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit gotD;
        int dCnt;
        int ifCnt;
        int n;

        // Power-on reset: outputs forced to zero asynchronously.
        #1 rst = 1'b1;
        #2 checkAllZero("reset");
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single IF read.
        $display("[TB] single fetch read");
        applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 1, 4);
        @(negedge clk); checkOutput("T2 busy N", {31'b0, busy}, 32'd0);
        @(negedge clk); checkOutput("T2 busy N+1", {31'b0, busy}, 32'd1);
        @(posedge clk); #1 if_req = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); checkOutput("T2 busy N+2..4", {31'b0, busy}, 32'd1);
        end
        @(negedge clk); checkOutput("T2 busy N+5", {31'b0, busy}, 32'd0);
        idle(1);

        // Single D write.
        $display("[TB] single data write");
        applyStimulus(1'b1, 1'b1, 8'h20, 32'h0000CAFE, 1, -1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk); checkOutput("T3 busy N+2", {31'b0, busy}, 32'd0);
        idle(3);

        // Both request together: D first, IF re-arbitrated afterwards.
        $display("[TB] simultaneous requests");
        applyStimulus(1'b1, 1'b0, 8'h30, 32'h0, 1, 4);
        applyStimulus(1'b0, 1'b0, 8'h31, 32'h0, 6, 9);
        grantAndDrop("T4 first");
        grantAndDrop("T4 second");
        idle(5);

        // Starvation guard: three D wins, then IF; counter then restarts.
        $display("[TB] starvation guard");
        n = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h70; d_wdata = 32'h10000000;
        if_req = 1'b1; if_addr = 8'h50;
        pushExpect(1'b1, 1'b1, 8'h70, 32'h10000000, n + 1, -1);
        pushExpect(1'b1, 1'b1, 8'h71, 32'h10000001, n + 3, -1);
        pushExpect(1'b1, 1'b1, 8'h72, 32'h10000002, n + 5, -1);
        pushExpect(1'b0, 1'b0, 8'h50, 32'h0, n + 7, n + 10);
        pushExpect(1'b1, 1'b1, 8'h73, 32'h10000003, n + 12, -1);
        pushExpect(1'b1, 1'b1, 8'h74, 32'h10000004, n + 14, -1);
        pushExpect(1'b1, 1'b1, 8'h75, 32'h10000005, n + 16, -1);
        pushExpect(1'b0, 1'b0, 8'h51, 32'h0, n + 18, n + 21);
        dCnt = 0;
        ifCnt = 0;
        for (int k = 0; k < 8; k++) begin
            waitAnyGnt("T5", gotD);
            if (gotD) begin
                dCnt++;
                if (dCnt < 6) begin
                    d_addr  = 8'h70 + 8'(dCnt);
                    d_wdata = 32'h10000000 + 32'(dCnt);
                end else begin
                    d_req = 1'b0;
                end
            end else begin
                ifCnt++;
                if (ifCnt < 2) if_addr = 8'h51;
                else           if_req = 1'b0;
            end
        end
        idle(5);

        // IF request raised during D's WAIT and withdrawn before IDLE.
        $display("[TB] withdrawn request");
        applyStimulus(1'b1, 1'b0, 8'h60, 32'h0, 1, 4);
        grantAndDrop("T6");
        if_req = 1'b1; if_addr = 8'h61;
        idle(2);
        if_req = 1'b0;
        idle(4);
        checkOutput("T6 scoreboard drained", gntQ.size() + rvQ.size(), 32'd0);

        // Reset in the middle of an IF read's WAIT: access is discarded.
        $display("[TB] reset mid-transaction");
        applyStimulus(1'b0, 1'b0, 8'h40, 32'h0, 1, -1);
        grantAndDrop("T1");
        checkOutput("T1 busy before reset", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1 checkAllZero("T1 mid-WAIT reset");
        idle(1);
        rst = 1'b0;
        idle(8);
        checkOutput("T1 busy after reset", {31'b0, busy}, 32'd0);
        checkOutput("final scoreboard drained", gntQ.size() + rvQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
